// File: rtl/tinydec_feed_if.sv
// Handshake bundle for tinydec_feed: byte input stream, block output stream and core req/ack.
// master is the feeder's view; slave is the view of the surrounding transport, sink and core.
interface tinydec_feed_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        core_req;
  logic [31:0] core_wdata;
  logic        core_ack;
  logic [31:0] core_rdata;

  modport master (
    input  in_data, in_valid, out_ready, core_ack, core_rdata,
    output in_ready, out_data, out_valid, core_req, core_wdata
  );

  modport slave (
    output in_data, in_valid, out_ready, core_ack, core_rdata,
    input  in_ready, out_data, out_valid, core_req, core_wdata
  );
endinterface

// File: rtl/tinydec_feed.sv
// Byte-to-block feeder for the tinydec core: assembles 32-bit words, queues them, and runs one core
// request at a time. Define TINYDEC_FEED_BSWAP_EN for big-endian byte assembly.
module tinydec_feed #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic           flush,
  tinydec_feed_if.master bus,
  output logic [AW:0]    level,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    bc;
  logic [1:0]    lane;
  logic [31:0]   partial;
  logic [31:0]   assembled;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          accept;
  logic          push;
  logic          pop;

  // in_ready is held low while rstb is asserted so the transport sees no capacity during reset.
  assign full         = (level == (AW+1)'(DEPTH));
  assign bus.in_ready = rstb && !full && !flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && (bc == 2'd3);
  assign pop          = (state == IDLE) && (level != '0) && !bus.out_valid
                        && bus.core_ack && !flush;
  assign busy         = (state != IDLE);

`ifdef TINYDEC_FEED_BSWAP_EN
  assign lane = ~bc;
`else
  assign lane = bc;
`endif

  always_comb begin
    assembled = partial;
    assembled[{lane, 3'b000} +: 8] = bus.in_data;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      bc      <= 2'd0;
      partial <= '0;
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
    end else if (flush) begin
      bc    <= 2'd0;
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (accept) begin
        bc      <= bc + 2'd1;
        partial <= assembled;
      end
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      level <= level + (AW+1)'(1);
      else if (pop && !push) level <= level - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= assembled;
  end

  // One block in flight: req is held until the core drops ack, result captured when ack returns.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state          <= IDLE;
      bus.core_req   <= 1'b0;
      bus.core_wdata <= '0;
      bus.out_data   <= '0;
      bus.out_valid  <= 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            bus.core_wdata <= mem[rptr];
            bus.core_req   <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (!bus.core_ack) begin
            bus.core_req <= 1'b0;
            state        <= RUN;
          end
        end
        RUN: begin
          if (bus.core_ack) begin
            bus.out_data  <= bus.core_rdata;
            bus.out_valid <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinydec_feed.sv
// Directed bench for tinydec_feed with a scoreboard of queued words and expected core results,
// and a behavioural core whose result is the ciphertext XOR a fixed key.
module tb_tinydec_feed;

  localparam logic [31:0] KEY = 32'h9A9E9CFE;
`ifdef TINYDEC_FEED_BSWAP_EN
  localparam logic [31:0] FIRST_WORD = 32'h11223344;
`else
  localparam logic [31:0] FIRST_WORD = 32'h44332211;
`endif
  localparam logic [31:0] FIRST_RESULT = FIRST_WORD ^ KEY;

  logic       clk = 1'b0;
  logic       rstb;
  logic       flush;
  logic [2:0] level;
  logic       busy;

  tinydec_feed_if bus ();

  tinydec_feed #(.DEPTH(4), .AW(2)) dut (
    .clk   (clk),
    .rstb  (rstb),
    .flush (flush),
    .bus   (bus),
    .level (level),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] wq[$];
  logic [31:0] rq[$];
  logic [31:0] pending_w;
  bit          pending_valid = 0;
  logic [31:0] pword = '0;
  int          pbc = 0;
  bit          req_prev = 0;
  bit          stall = 0;
  int          core_rounds = 1;
  int          core_cnt = 0;
  logic [31:0] core_result = '0;
  logic        next_ack = 1'b1;
  logic [31:0] next_rdata = '0;
  int          accepts = 0;
  bit          last_accept = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Evaluated at negedge: inputs/outputs here are what the DUT samples on the coming edge.
  task automatic monitor();
    logic [31:0] r;
    if (bus.core_req && !req_prev) begin
      check_output("issue_single", 32'(pending_valid), 32'd0);
      check_output("issue_nonempty", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) pending_w = wq.pop_front();
      pending_valid = 1;
    end
    req_prev = bus.core_req;
    check_output("level", 32'(level), 32'(wq.size()));
    check_output("in_ready", 32'(bus.in_ready), 32'(rstb && (wq.size() != 4) && !flush));

    if (bus.core_req && bus.core_ack && !stall) begin
      check_output("req_has_block", 32'(pending_valid), 32'd1);
      check_output("core_wdata", bus.core_wdata, pending_w);
      pending_valid = 0;
      accepts++;
      core_result = pending_w ^ KEY;
      rq.push_back(core_result);
      core_cnt   = core_rounds;
      next_ack   = 1'b0;
      next_rdata = $urandom();
    end else if (core_cnt > 0) begin
      core_cnt--;
      next_ack   = (core_cnt == 0) && !stall;
      next_rdata = next_ack ? core_result : $urandom();
    end else begin
      next_ack   = !stall;
      next_rdata = core_result;
    end

    if (bus.out_valid && bus.out_ready) begin
      check_output("out_expected", 32'(rq.size() != 0), 32'd1);
      if (rq.size() != 0) begin
        r = rq.pop_front();
        check_output("out_data", bus.out_data, r);
      end
    end

    if (bus.in_valid && bus.in_ready) begin
      last_accept = 1;
`ifdef TINYDEC_FEED_BSWAP_EN
      pword[8*(3-pbc) +: 8] = bus.in_data;
`else
      pword[8*pbc +: 8] = bus.in_data;
`endif
      pbc++;
      if (pbc == 4) begin
        wq.push_back(pword);
        pbc = 0;
      end
    end
    if (flush) begin
      wq.delete();
      pbc = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    bus.core_ack   = next_ack;
    bus.core_rdata = next_rdata;
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    int n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    last_accept  = 0;
    while (!last_accept && n < 100) begin
      cycle();
      n++;
    end
    check_output("byte_accepted", 32'(last_accept), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) apply_stimulus(w[8*i +: 8]);
  endtask

  task automatic wait_core_accept();
    int a = accepts;
    int n = 0;
    while (accepts == a && n < 100) begin
      cycle();
      n++;
    end
    check_output("core_accept_seen", 32'(accepts != a), 32'd1);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      cycle();
      n++;
    end
    check_output("out_valid_seen", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    bus.out_ready = 1'b1;
    while ((wq.size() != 0 || rq.size() != 0 || pending_valid || bus.out_valid) && n < 500) begin
      cycle();
      n++;
    end
    check_output("drain_done", 32'(n < 500), 32'd1);
  endtask

  task automatic set_stall(input bit s);
    stall = s;
    if (s) begin
      next_ack     = 1'b0;
      bus.core_ack = 1'b0;
    end
  endtask

  initial begin
    rstb           = 1'b0;
    flush          = 1'b0;
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.core_ack   = 1'b1;
    bus.core_rdata = '0;

    #2;
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_core_req", 32'(bus.core_req), 32'd0);
    check_output("rst_level", 32'(level), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_out_data", bus.out_data, 32'd0);
    check_output("rst_core_wdata", bus.core_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    #1 check_output("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    $display("[TB] first block, R=1, out_ready held low");
    apply_stimulus(8'h11);
    apply_stimulus(8'h22);
    apply_stimulus(8'h33);
    apply_stimulus(8'h44);
    check_output("first_level", 32'(level), 32'd1);
    cycle();
    check_output("first_core_req", 32'(bus.core_req), 32'd1);
    check_output("first_core_wdata", bus.core_wdata, FIRST_WORD);
    wait_out_valid();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_output("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check_output("hold_out_data", bus.out_data, FIRST_RESULT);
    end
    bus.out_ready = 1'b1;
    cycle();
    check_output("consumed_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("single_request", 32'(accepts), 32'd1);

    $display("[TB] fill FIFO with core stalled");
    set_stall(1);
    for (int i = 0; i < 16; i++) apply_stimulus(8'(8'h40 + 8'(i * 7)));
    check_output("full_level", 32'(level), 32'd4);
    check_output("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_data  = 8'hA7;
    bus.in_valid = 1'b1;
    last_accept  = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_output("full_no_accept", 32'(last_accept), 32'd0);
    end
    set_stall(0);
    apply_stimulus(8'hA7);
    apply_stimulus(8'hB8);
    apply_stimulus(8'hC9);
    apply_stimulus(8'hDA);
    drain();

    $display("[TB] two words with out_ready low");
    bus.out_ready = 1'b0;
    send_word(32'h0403_0201);
    send_word(32'h8877_6655);
    wait_out_valid();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_output("blocked_level", 32'(level), 32'd1);
      check_output("blocked_core_req", 32'(bus.core_req), 32'd0);
      check_output("blocked_busy", 32'(busy), 32'd0);
    end
    drain();

    $display("[TB] flush while RUN after 2 bytes");
    core_rounds = 12;
    send_word(32'hCAFE_F00D);
    wait_core_accept();
    send_word(32'h1357_9BDF);
    apply_stimulus(8'hE1);
    apply_stimulus(8'hE2);
    check_output("flush_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    #1 check_output("flush_in_ready", 32'(bus.in_ready), 32'd0);
    cycle();
    flush = 1'b0;
    check_output("flush_level", 32'(level), 32'd0);
    send_word(32'h2468_ACE0);
    drain();

    $display("[TB] reset during RUN");
    core_rounds = 3;
    send_word(32'h0F1E_2D3C);
    wait_core_accept();
    cycle();
    cycle();
    rstb = 1'b0;
    #1;
    check_output("midrst_core_req", 32'(bus.core_req), 32'd0);
    check_output("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("midrst_level", 32'(level), 32'd0);
    check_output("midrst_busy", 32'(busy), 32'd0);
    wq.delete();
    rq.delete();
    pending_valid = 0;
    pbc           = 0;
    req_prev      = 0;
    core_cnt      = 0;
    next_ack      = 1'b1;
    bus.core_ack  = 1'b1;
    cycle();
    cycle();
    rstb = 1'b1;
    send_word(32'h5A5A_1234);
    send_word(32'h0BEE_F00D);
    drain();
    check_output("final_level", 32'(level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
